// File: rtl/nasti_arb_pkg.sv
// Shared types for the NASTI read arbiter: AR payload layout and FSM states.
package nasti_arb_pkg;

    localparam int ID_W   = 2;
    localparam int ADDR_W = 32;
    localparam int USER_W = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } NastiArReq;

    localparam int AR_W = $bits(NastiArReq);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    localparam logic [PTR_W:0] N_L = (PTR_W+1)'(N);

    logic [PTR_W:0] pos;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = {1'b0, ptr};
        for (int k = 0; k < N; k++) begin
            if (!found && req[pos[PTR_W-1:0]]) begin
                grant[pos[PTR_W-1:0]] = 1'b1;
                found = 1'b1;
            end
            pos = pos + (PTR_W+1)'(1);
            if (pos >= N_L) begin
                pos = '0;
            end
        end
    end

endmodule

// File: rtl/nasti_read_arbiter.sv
// Round-robin arbiter of N read masters onto one NASTI slave port,
// one transaction outstanding at a time, with sticky R-channel protocol checking.
module nasti_read_arbiter
    import nasti_arb_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rstn,

    input  logic [N_MASTERS*AR_W-1:0] m_ar_req,
    input  logic [N_MASTERS-1:0]      m_ar_valid,
    output logic [N_MASTERS-1:0]      m_ar_ready,

    output logic [ID_WIDTH-1:0]       m_r_id,
    output logic [DATA_WIDTH-1:0]     m_r_data,
    output logic [1:0]                m_r_resp,
    output logic                      m_r_last,
    output logic [USER_WIDTH-1:0]     m_r_user,
    output logic [N_MASTERS-1:0]      m_r_valid,
    input  logic [N_MASTERS-1:0]      m_r_ready,

    output logic [AR_W-1:0]           s_ar_req,
    output logic                      s_ar_valid,
    input  logic                      s_ar_ready,

    input  logic [ID_WIDTH-1:0]       s_r_id,
    input  logic [DATA_WIDTH-1:0]     s_r_data,
    input  logic [1:0]                s_r_resp,
    input  logic                      s_r_last,
    input  logic [USER_WIDTH-1:0]     s_r_user,
    input  logic                      s_r_valid,
    output logic                      s_r_ready,

    output logic                      err
);

    // The AR payload layout is fixed by the package, so the field widths must agree.
    if (ID_WIDTH != ID_W || ADDR_WIDTH != ADDR_W || USER_WIDTH != USER_W) begin : g_bad_widths
        $error("nasti_read_arbiter: field widths disagree with nasti_arb_pkg");
    end
    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_masters
        $error("nasti_read_arbiter: N_MASTERS must be 2..8");
    end

    localparam int PTR_W = $clog2(N_MASTERS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_MASTERS - 1);

    arb_state_e           state, state_next;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     win_idx;
    logic [N_MASTERS-1:0] win_oh;
    NastiArReq            win_req;
    NastiArReq            req_q;
    logic [7:0]           beat_cnt;
    logic                 err_q;
    logic                 ar_accept;
    logic                 r_hs;
    logic                 beat_err;

    rr_arbiter #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (m_ar_valid),
        .ptr   (rr_ptr),
        .grant (win_oh)
    );

    always_comb begin
        win_idx = '0;
        win_req = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (win_oh[i]) begin
                win_idx = PTR_W'(i);
                win_req = m_ar_req[i*AR_W +: AR_W];
            end
        end
    end

    // The winner only carries a bit where a master is valid, so any grant is an accept.
    assign ar_accept = rstn && (state == S_IDLE) && (|win_oh);
    assign r_hs      = (state == S_R) && s_r_valid && s_r_ready;
    assign beat_err  = (s_r_id != req_q.id)
                     || ( s_r_last && (beat_cnt != req_q.len))
                     || (!s_r_last && (beat_cnt == req_q.len));

    always_comb begin
        state_next = state;
        m_ar_ready = '0;
        s_ar_valid = 1'b0;
        s_r_ready  = 1'b0;
        m_r_valid  = '0;
        case (state)
            S_IDLE: begin
                if (rstn) begin
                    m_ar_ready = win_oh;
                end
                if (ar_accept) begin
                    state_next = S_AR;
                end
            end
            S_AR: begin
                s_ar_valid = 1'b1;
                if (s_ar_ready) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                s_r_ready            = m_r_ready[grant_idx];
                m_r_valid[grant_idx] = s_r_valid;
                if (s_r_valid && m_r_ready[grant_idx] && s_r_last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
            err_q     <= 1'b0;
            req_q     <= '0;
        end else begin
            state <= state_next;
            if (ar_accept) begin
                req_q     <= win_req;
                grant_idx <= win_idx;
                beat_cnt  <= '0;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (beat_err) begin
                    err_q <= 1'b1;
                end
                if (s_r_last) begin
                    rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
                end
            end
        end
    end

    assign s_ar_req = req_q;
    assign m_r_id   = s_r_id;
    assign m_r_data = s_r_data;
    assign m_r_resp = s_r_resp;
    assign m_r_last = s_r_last;
    assign m_r_user = s_r_user;
    assign err      = err_q;

endmodule

// File: tb/tb_nasti_read_arbiter.sv
// Directed self-checking bench for nasti_read_arbiter with two masters.
module tb_nasti_read_arbiter;
    import nasti_arb_pkg::*;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N*AR_W-1:0] m_ar_req;
    logic [N-1:0]      m_ar_valid;
    logic [N-1:0]      m_ar_ready;
    logic [1:0]        m_r_id;
    logic [63:0]       m_r_data;
    logic [1:0]        m_r_resp;
    logic              m_r_last;
    logic [0:0]        m_r_user;
    logic [N-1:0]      m_r_valid;
    logic [N-1:0]      m_r_ready;
    logic [AR_W-1:0]   s_ar_req;
    logic              s_ar_valid;
    logic              s_ar_ready;
    logic [1:0]        s_r_id;
    logic [63:0]       s_r_data;
    logic [1:0]        s_r_resp;
    logic              s_r_last;
    logic [0:0]        s_r_user;
    logic              s_r_valid;
    logic              s_r_ready;
    logic              err;

    int cmp_count  = 0;
    int fail_count = 0;

    NastiArReq p0, p1;

    nasti_read_arbiter #(.N_MASTERS(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .m_ar_req   (m_ar_req),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_r_id     (m_r_id),
        .m_r_data   (m_r_data),
        .m_r_resp   (m_r_resp),
        .m_r_last   (m_r_last),
        .m_r_user   (m_r_user),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .s_ar_req   (s_ar_req),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_r_id     (s_r_id),
        .s_r_data   (s_r_data),
        .s_r_resp   (s_r_resp),
        .s_r_last   (s_r_last),
        .s_r_user   (s_r_user),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_count++;
        assert (obs === exp) else begin
            fail_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // Drives the slave R channel, then lets combinational outputs settle.
    task automatic applyStimulus(input logic sv, input logic [1:0] id, input logic [63:0] data,
                                 input logic last);
        s_r_valid = sv;
        s_r_id    = id;
        s_r_data  = data;
        s_r_last  = last;
        s_r_resp  = 2'b00;
        s_r_user  = 1'b0;
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        return N'(1) << g;
    endfunction

    // Expects master g to win arbitration now; walks AR through a slave that waits wait_cycles.
    task automatic do_ar(input int g, input NastiArReq p, input int wait_cycles);
        #1;
        checkOutput("ar_grant", 64'(m_ar_ready), 64'(onehot(g)));
        checkOutput("ar_idle_s_ar_valid", 64'(s_ar_valid), 64'd0);
        tick();
        applyStimulus(1'b1, p.id, 64'hD000, 1'b0);
        checkOutput("ar_s_ar_valid", 64'(s_ar_valid), 64'd1);
        checkOutput("ar_s_ar_req", 64'(s_ar_req), 64'(p));
        checkOutput("ar_busy_m_ar_ready", 64'(m_ar_ready), 64'd0);
        checkOutput("ar_early_beat_stalled", 64'(s_r_ready), 64'd0);
        checkOutput("ar_early_m_r_valid", 64'(m_r_valid), 64'd0);
        for (int w = 0; w < wait_cycles; w++) begin
            tick();
            checkOutput("ar_hold_valid", 64'(s_ar_valid), 64'd1);
            checkOutput("ar_hold_req", 64'(s_ar_req), 64'(p));
        end
        s_ar_ready = 1'b1;
        tick();
        s_ar_ready = 1'b0;
    endtask

    // Sends nbeats beats for master g; optionally stalls its m_r_ready before beat stall_beat.
    task automatic run_burst(input int g, input int nbeats, input logic [1:0] id,
                             input int stall_beat, input int stall_len);
        logic [N-1:0] oh;
        oh = onehot(g);
        for (int b = 0; b < nbeats; b++) begin
            applyStimulus(1'b1, id, 64'hD000 + 64'(b), b == nbeats - 1);
            if (b == stall_beat) begin
                m_r_ready = ~oh;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    checkOutput("stall_s_r_ready", 64'(s_r_ready), 64'd0);
                    checkOutput("stall_m_r_valid", 64'(m_r_valid), 64'(oh));
                    tick();
                end
                m_r_ready = '1;
                #1;
            end
            checkOutput("r_m_r_valid", 64'(m_r_valid), 64'(oh));
            checkOutput("r_s_r_ready", 64'(s_r_ready), 64'd1);
            checkOutput("r_data", m_r_data, 64'hD000 + 64'(b));
            checkOutput("r_last", 64'(m_r_last), 64'(b == nbeats - 1));
            tick();
        end
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0);
        checkOutput("r_done_m_r_valid", 64'(m_r_valid), 64'd0);
        checkOutput("r_done_s_r_ready", 64'(s_r_ready), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_m_ar_ready"}, 64'(m_ar_ready), 64'd0);
        checkOutput({tag, "_m_r_valid"}, 64'(m_r_valid), 64'd0);
        checkOutput({tag, "_s_ar_valid"}, 64'(s_ar_valid), 64'd0);
        checkOutput({tag, "_s_r_ready"}, 64'(s_r_ready), 64'd0);
    endtask

    int exp_order [4] = '{0, 1, 0, 1};

    initial begin
        p0 = '0;
        p0.id = 2'd1; p0.addr = 32'h0000_1000; p0.len = 8'd3; p0.size = 3'd3; p0.burst = 2'b01;
        p1 = '0;
        p1.id = 2'd2; p1.addr = 32'h0000_2000; p1.len = 8'd1; p1.size = 3'd3; p1.burst = 2'b01;
        p1.cache = 4'h3; p1.qos = 4'h5;
        m_ar_req   = {p1, p0};
        m_ar_valid = 2'b11;
        m_r_ready  = '1;
        s_ar_ready = 1'b0;
        rstn       = 1'b0;
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0);

        // Reset state, with both masters already requesting.
        tick();
        tick();
        check_quiet("reset");
        checkOutput("reset_err", 64'(err), 64'd0);
        m_ar_valid = 2'b00;
        rstn = 1'b1;
        tick();
        #1;
        checkOutput("idle_no_valid_ready", 64'(m_ar_ready), 64'd0);

        // Single master-0 read, len=3, slave AR waits two cycles.
        $display("[TB] single read from master 0");
        m_ar_valid = 2'b01;
        do_ar(0, p0, 2);
        m_ar_valid = 2'b00;
        run_burst(0, 4, 2'd1, -1, 0);
        checkOutput("single_err", 64'(err), 64'd0);

        // Round robin from reset with both masters requesting; burst stall on master 1.
        $display("[TB] round robin 0,1,0,1");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        m_ar_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            if (exp_order[t] == 0) begin
                do_ar(0, p0, 0);
                run_burst(0, 4, 2'd1, -1, 0);
            end else begin
                do_ar(1, p1, 0);
                run_burst(1, 2, 2'd2, (t == 1) ? 1 : -1, 5);
            end
        end
        m_ar_valid = 2'b00;
        checkOutput("rr_err", 64'(err), 64'd0);

        // Early s_r_last on beat 2 of len=3.
        $display("[TB] early last");
        tick();
        m_ar_valid = 2'b01;
        do_ar(0, p0, 0);
        m_ar_valid = 2'b00;
        applyStimulus(1'b1, 2'd1, 64'hD000, 1'b0);
        tick();
        checkOutput("early_last_err_before", 64'(err), 64'd0);
        applyStimulus(1'b1, 2'd1, 64'hD001, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0);
        checkOutput("early_last_err", 64'(err), 64'd1);
        m_ar_valid = 2'b01;
        #1;
        checkOutput("early_last_idle", 64'(m_ar_ready), 64'b01);
        m_ar_valid = 2'b00;
        tick();
        tick();
        tick();
        checkOutput("early_last_err_sticky", 64'(err), 64'd1);

        // Reset mid-burst abandons the transaction; pointer restarts at master 0.
        $display("[TB] reset during burst");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checkOutput("reset_clears_err", 64'(err), 64'd0);
        m_ar_valid = 2'b10;
        do_ar(1, p1, 0);
        m_ar_valid = 2'b00;
        applyStimulus(1'b1, 2'd2, 64'hD000, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd2, 64'hD001, 1'b1);
        checkOutput("mid_burst_m_r_valid", 64'(m_r_valid), 64'b10);
        rstn = 1'b0;
        m_ar_valid = 2'b11;
        tick();
        check_quiet("mid_reset");
        rstn = 1'b1;
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0);
        checkOutput("post_reset_grant", 64'(m_ar_ready), 64'b01);
        tick();
        m_ar_valid = 2'b00;
        #1;
        checkOutput("post_reset_s_ar_req", 64'(s_ar_req), 64'(p0));
        s_ar_ready = 1'b1;
        tick();
        s_ar_ready = 1'b0;

        // Wrong id on one beat of an otherwise well-formed burst.
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, (b == 2) ? 2'd3 : 2'd1, 64'hE000 + 64'(b), b == 3);
            checkOutput("id_err_beat_ready", 64'(s_r_ready), 64'd1);
            if (b == 2) begin
                checkOutput("id_err_before", 64'(err), 64'd0);
            end
            tick();
        end
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0);
        checkOutput("id_err", 64'(err), 64'd1);

        // Missing s_r_last on the final counted beat, ending one beat late.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        m_ar_valid = 2'b10;
        do_ar(1, p1, 0);
        m_ar_valid = 2'b00;
        applyStimulus(1'b1, 2'd2, 64'hF000, 1'b0);
        tick();
        checkOutput("late_last_err_before", 64'(err), 64'd0);
        applyStimulus(1'b1, 2'd2, 64'hF001, 1'b0);
        tick();
        checkOutput("late_last_err", 64'(err), 64'd1);
        checkOutput("late_last_still_in_r", 64'(m_r_valid), 64'b10);
        applyStimulus(1'b1, 2'd2, 64'hF002, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0);
        m_ar_valid = 2'b11;
        #1;
        checkOutput("late_last_next_grant", 64'(m_ar_ready), 64'b01);
        m_ar_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/nasti_read_arbiter.md
NASTI_READ_ARBITER -- requirements
Module: nasti_read_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2: number of requesting read masters, 2..8.
REQ-002 Parameters ID_WIDTH 2, ADDR_WIDTH 32, DATA_WIDTH 64, USER_WIDTH 1: NASTI field widths, identical on master and slave sides.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 m_ar_req  in  N_MASTERS*AR_W  per-master AR payload packed as NastiArReq (id, addr, len, size, burst, lock, cache, prot, qos, region, user); master i at slice i.
REQ-006 m_ar_valid  in  N_MASTERS  per-master AR valid.
REQ-007 m_ar_ready  out  N_MASTERS  per-master AR ready.
REQ-008 m_r_id / m_r_data / m_r_resp / m_r_last / m_r_user  out  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH  R payload, shared by all masters.
REQ-009 m_r_valid  out  N_MASTERS  per-master R valid.
REQ-010 m_r_ready  in  N_MASTERS  per-master R ready.
REQ-011 s_ar_req  out  AR_W  AR payload to the shared slave port.
REQ-012 s_ar_valid  out  1 / s_ar_ready  in  1  slave AR handshake.
REQ-013 s_r_id / s_r_data / s_r_resp / s_r_last / s_r_user  in  as REQ-008  slave R payload.
REQ-014 s_r_valid  in  1 / s_r_ready  out  1  slave R handshake.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 FSM states S_IDLE, S_AR, S_R; at most one read transaction outstanding on the slave port.
REQ-017 S_IDLE: winner = first i with m_ar_valid[i], searching from rr_ptr upward, wrapping N_MASTERS-1 to 0; m_ar_ready = onehot(winner) only when any valid, else all 0.
REQ-018 On m_ar_valid[g] && m_ar_ready[g]: latch payload and g, clear beat counter, go to S_AR next cycle.
REQ-019 S_AR: s_ar_valid = 1, s_ar_req = latched payload, held stable until s_ar_ready; on handshake go to S_R; s_ar_valid is 0 in all other states.
REQ-020 S_R: m_r_valid[g] = s_r_valid, other bits 0; s_r_ready = m_r_ready[g]; R payload passes combinationally (zero-cycle latency).
REQ-021 s_r_ready = 0 outside S_R; slave beats arriving outside S_R are stalled, not dropped.
REQ-022 Beat counter (8 bits) increments on each S_R R handshake.
REQ-023 On R handshake with s_r_last = 1: return to S_IDLE, rr_ptr <= (g+1) mod N_MASTERS; minimum AR-to-AR spacing for back-to-back grants is 3 cycles plus slave latency.
REQ-024 err set if an S_R beat has s_r_id != latched id, or s_r_last = 1 with counter != latched len, or counter == latched len with s_r_last = 0; err cleared only by reset.
REQ-025 Protocol errors do not alter sequencing; transaction still ends on s_r_last.
REQ-026 Master dropping m_ar_valid before handshake is not granted; arbitration re-evaluated every S_IDLE cycle.

Reset
REQ-027 rstn low at a clock edge: state S_IDLE, rr_ptr 0, grant 0, counter 0, err 0; an in-flight transaction is abandoned (slave assumed reset together).
REQ-028 While in reset state, m_ar_ready, m_r_valid, s_ar_valid, s_r_ready all 0 the cycle after the reset edge.

Structure
REQ-029 Package nasti_arb_pkg holds NastiArReq typedef, AR_W constant and FSM state enum.
REQ-030 One sub-module, rr_arbiter (request vector + pointer in, one-hot grant out, combinational), instantiated once.

Verification
REQ-031 Reset, then master 0 AR len=3 id=1 -> s_ar_valid 1 cycle after accept, 4 beats routed only to m_r_valid[0], err 0.
REQ-032 Masters 0,1 valid simultaneously from reset -> grant order 0,1,0,1 over four transactions.
REQ-033 m_r_ready[g] held 0 for 5 cycles mid-burst -> s_r_ready 0 for same cycles, no beat lost or duplicated.
REQ-034 Slave returns s_r_last on beat 2 of len=3 -> err 1, FSM back to S_IDLE, err stays 1 until reset.
REQ-035 rstn asserted during S_R beat 1 -> all valid/ready outputs 0 next cycle; new request after release granted to master 0.
